// File: rtl/eth_tx_frame_fifo_if.sv
`timescale 1ns/1ps
// AXI-Stream bundle used on both sides of the Ethernet TX frame FIFO.
interface eth_tx_frame_fifo_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_tx_frame_fifo.sv
`timescale 1ns/1ps
// Store-and-forward AXI-Stream frame FIFO feeding the 10G MAC TX port; bad or oversize frames are dropped whole.
// Define ETH_TX_FIFO_STATS_EN to add saturating stat_tx_frames / stat_drop_frames counters.
module eth_tx_frame_fifo #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                clock,
  input  logic                resetn,
  eth_tx_frame_fifo_if.slave  s_axis,
  eth_tx_frame_fifo_if.master m_axis,
  output logic [ADDR_WIDTH:0] frames_queued,
  output logic                overflow
`ifdef ETH_TX_FIFO_STATS_EN
  ,
  output logic [31:0]         stat_tx_frames,
  output logic [31:0]         stat_drop_frames
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int WORD_W = DATA_WIDTH + KEEP_W + 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef enum logic {ACCEPT = 1'b0, DROP = 1'b1} wr_state_t;

  wr_state_t         state;
  wr_state_t         state_next;
  ptr_t              wr_ptr;
  ptr_t              wr_commit;
  ptr_t              rd_ptr;
  logic              ready;
  logic              full;
  logic              beat;
  logic              wr_en;
  logic              commit;
  logic              rewind;
  logic              drop_evt;
  logic              rd_en_p0;
  logic              vld_p1;
  logic              fire;
  logic              last_fire;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] word_p1;

  assign s_axis.tready = ready;
  assign beat          = s_axis.tvalid & ready;
  assign full          = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                         (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  always_ff @(posedge clock) begin
    if (!resetn) state <= ACCEPT;
    else         state <= state_next;
  end

  // A frame that hits full mid-way is discarded until its tlast, then wr_ptr rewinds to the last commit.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    drop_evt   = 1'b0;
    case (state)
      ACCEPT: begin
        if (beat) begin
          if (!full) begin
            wr_en = 1'b1;
            if (s_axis.tlast) begin
              if (s_axis.tuser) begin
                rewind   = 1'b1;
                drop_evt = 1'b1;
              end else begin
                commit = 1'b1;
              end
            end
          end else if (s_axis.tlast) begin
            rewind   = 1'b1;
            drop_evt = 1'b1;
          end else begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        if (beat && s_axis.tlast) begin
          rewind     = 1'b1;
          drop_evt   = 1'b1;
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ready     <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      ready <= 1'b1;
      if (rewind)     wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (commit)     wr_commit <= wr_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  // p0: issue a RAM read of committed data when the output register is free or draining
  assign fire      = vld_p1 & m_axis.tready;
  assign last_fire = fire & word_p1[WORD_W-1];
  assign rd_en_p0  = (rd_ptr != wr_commit) && (!vld_p1 || fire);

  // p1: RAM read register doubles as the first-word-fall-through output register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else if (rd_en_p0) begin
      rd_ptr  <= rd_ptr + ptr_t'(1);
      vld_p1  <= 1'b1;
      word_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else if (fire) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis.tdata  = word_p1[DATA_WIDTH-1:0];
  assign m_axis.tkeep  = word_p1[DATA_WIDTH +: KEEP_W];
  assign m_axis.tlast  = word_p1[WORD_W-1];
  assign m_axis.tvalid = vld_p1;
  assign m_axis.tuser  = 1'b0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      frames_queued <= '0;
      overflow      <= 1'b0;
    end else begin
      overflow <= drop_evt;
      if (commit && !last_fire)      frames_queued <= frames_queued + ptr_t'(1);
      else if (!commit && last_fire) frames_queued <= frames_queued - ptr_t'(1);
    end
  end

`ifdef ETH_TX_FIFO_STATS_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else begin
      if (last_fire && (stat_tx_frames != '1))  stat_tx_frames   <= stat_tx_frames + 32'd1;
      if (drop_evt && (stat_drop_frames != '1)) stat_drop_frames <= stat_drop_frames + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
`timescale 1ns/1ps
// Bench for eth_tx_frame_fifo: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a frame-level model (kept frames, free space, drop count).
module tb_eth_tx_frame_fifo;
  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [AW:0] frames_queued;
  logic        overflow;
`ifdef ETH_TX_FIFO_STATS_EN
  logic [31:0] stat_tx_frames;
  logic [31:0] stat_drop_frames;
`endif

  eth_tx_frame_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  eth_tx_frame_fifo_if #(.DATA_WIDTH(DW)) m_if ();

  eth_tx_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .frames_queued (frames_queued),
    .overflow      (overflow)
`ifdef ETH_TX_FIFO_STATS_EN
    ,
    .stat_tx_frames   (stat_tx_frames),
    .stat_drop_frames (stat_drop_frames)
`endif
  );

  initial forever #5 clock = ~clock;

  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct { int len; logic [7:0] lkeep; logic bad; int rmode; int exp_ovf; int exp_lat; } vec_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          rx_beats = 0;
  int          rx_frames = 0;
  int          kept_words = 0;
  int          ovf_seen = 0;
  int          first_vld_cyc = -1;
  int          first_beat_cyc = -1;
  int          last_beat_cyc = -1;
  int          t_last_cyc = 0;
  logic [AW:0] fq_first = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MAC-side ready pattern: 0 always, 1 toggling, 2 random, other hold low
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        2:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    beat_t e;
    beat_t held;
    logic  stall_prev;
    stall_prev = 1'b0;
    held = '{64'h0, 8'h0, 1'b0};
    forever begin
      @(negedge clock);
      if (overflow) ovf_seen++;
      if (resetn && stall_prev) begin
        chk("hold_ctl", 64'({m_if.tvalid, m_if.tlast, m_if.tkeep}), 64'({1'b1, held.last, held.keep}));
        chk("hold_data", m_if.tdata, held.data);
      end
      if (m_if.tvalid && first_vld_cyc < 0) begin
        first_vld_cyc = cyc;
        fq_first      = frames_queued;
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_if.tdata, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_if.tdata, e.data);
          chk("beat_ctl", 64'({m_if.tuser, m_if.tlast, m_if.tkeep}), 64'({1'b0, e.last, e.keep}));
        end
        rx_beats++;
        if (m_if.tlast) rx_frames++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      held       = '{m_if.tdata, m_if.tkeep, m_if.tlast};
    end
  end

  // Called just after a rising edge; every beat is accepted because tready is 1 out of reset.
  task automatic send_frame(input int len, input logic [7:0] lkeep, input logic bad,
                            input bit keep_exp, input int gap_pct);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_if.tvalid = 1'b0;
        @(posedge clock); #1;
      end
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.keep = b.last ? lkeep : 8'hFF;
      s_if.tdata  = b.data;
      s_if.tkeep  = b.keep;
      s_if.tlast  = b.last;
      s_if.tuser  = b.last ? bad : 1'($urandom_range(0, 1));
      s_if.tvalid = 1'b1;
      if (b.last) t_last_cyc = cyc;
      if (keep_exp) exp_q.push_back(b);
      @(posedge clock); #1;
    end
    if (keep_exp) kept_words += len;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < maxc) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_timeout", 64'(n >= maxc), 64'(0));
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin : main
    vec_t       vt[6];
    int         o0, r0, n, drops, len, tx0, d0;
    logic       bad;
    bit         kp;
    logic [7:0] lk;

    vt[0] = '{8,  8'hFF, 1'b0, 0, 0, 2};
    vt[1] = '{8,  8'h0F, 1'b0, 1, 0, 2};
    vt[2] = '{4,  8'hFF, 1'b1, 0, 1, -1};
    vt[3] = '{1,  8'h01, 1'b0, 0, 0, 2};
    vt[4] = '{17, 8'hFF, 1'b0, 0, 1, -1};
    vt[5] = '{16, 8'h3F, 1'b0, 1, 0, 2};

    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tvalid = 1'b0;
    tx0 = 0;
    d0  = 0;

    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_tready", 64'(s_if.tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("rst_m_tdata", m_if.tdata, 64'(0));
    chk("rst_m_tkeep", 64'(m_if.tkeep), 64'(0));
    chk("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    chk("rst_m_tuser", 64'(m_if.tuser), 64'(0));
    chk("rst_frames_queued", 64'(frames_queued), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("tready_after_reset", 64'(s_if.tready), 64'(1));

    foreach (vt[i]) begin
      rdy_mode      = vt[i].rmode;
      first_vld_cyc = -1;
      o0            = ovf_seen;
      r0            = rx_beats;
      send_frame(vt[i].len, vt[i].lkeep, vt[i].bad, vt[i].exp_lat >= 0, 0);
      drain(300);
      if (vt[i].exp_lat >= 0) begin
        chk("latency", 64'(first_vld_cyc - t_last_cyc), 64'(vt[i].exp_lat));
        chk("fq_at_first_beat", 64'(fq_first), 64'(1));
        chk("beats_delivered", 64'(rx_beats - r0), 64'(vt[i].len));
      end else begin
        chk("dropped_no_output", 64'(first_vld_cyc < 0), 64'(1));
      end
      chk("vec_overflow", 64'(ovf_seen - o0), 64'(vt[i].exp_ovf));
      chk("vec_fq_end", 64'(frames_queued), 64'(0));
    end

    // Second frame overflows while the MAC holds tready low
    rdy_mode = 3;
    o0 = ovf_seen;
    r0 = rx_beats;
    send_frame(10, 8'hFF, 1'b0, 1'b1, 0);
    send_frame(10, 8'h07, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("ovf_fq_held", 64'(frames_queued), 64'(1));
    chk("ovf_pulses", 64'(ovf_seen - o0), 64'(1));
    rdy_mode = 0;
    drain(300);
    chk("ovf_drain_beats", 64'(rx_beats - r0), 64'(10));
    chk("ovf_fq_end", 64'(frames_queued), 64'(0));

    // Bad frame directly followed by a good one
    o0 = ovf_seen;
    r0 = rx_beats;
    send_frame(6, 8'hFF, 1'b1, 1'b0, 0);
    send_frame(7, 8'h03, 1'b0, 1'b1, 0);
    drain(300);
    chk("bad_ovf", 64'(ovf_seen - o0), 64'(1));
    chk("bad_good_beats", 64'(rx_beats - r0), 64'(7));

    // 200 back-to-back 9-beat frames, wrap and no-bubble throughput
    o0 = ovf_seen;
    r0 = rx_beats;
    first_beat_cyc = -1;
    for (int f = 0; f < 200; f++) send_frame(9, 8'hFF, 1'b0, 1'b1, 0);
    drain(600);
    chk("b2b_beats", 64'(rx_beats - r0), 64'(1800));
    chk("b2b_span", 64'(last_beat_cyc - first_beat_cyc), 64'(1799));
    chk("b2b_fq_end", 64'(frames_queued), 64'(0));
    chk("b2b_ovf", 64'(ovf_seen - o0), 64'(0));

    // Reset in the middle of a frame with one frame queued
    rdy_mode = 3;
    r0 = rx_beats;
    send_frame(8, 8'hFF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      s_if.tdata  = {$urandom, $urandom};
      s_if.tkeep  = 8'hFF;
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b1;
      @(posedge clock); #1;
    end
    chk("pre_reset_fq", 64'(frames_queued), 64'(1));
    resetn      = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tx0 = rx_frames;
    d0  = ovf_seen;
    chk("post_reset_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("post_reset_fq", 64'(frames_queued), 64'(0));
    chk("post_reset_tready", 64'(s_if.tready), 64'(1));
    rdy_mode = 0;
    repeat (20) @(posedge clock);
    #1;
    chk("post_reset_no_beats", 64'(rx_beats - r0), 64'(0));
    send_frame(5, 8'h7F, 1'b0, 1'b1, 0);
    drain(300);
    chk("post_reset_frame", 64'(rx_beats - r0), 64'(5));

    // Randomized traffic; good frames are only started when the model says they fit
    rdy_mode = 2;
    o0 = ovf_seen;
    drops = 0;
    for (int f = 0; f < 150; f++) begin
      len = $urandom_range(1, 20);
      bad = ($urandom_range(0, 7) == 0);
      kp  = !bad && (len <= DEPTH);
      lk  = 8'((32'd1 << $urandom_range(1, 8)) - 32'd1);
      if (kp) begin
        n = 0;
        while ((kept_words - rx_beats) + len > DEPTH && n < 5000) begin
          @(posedge clock); #1;
          n++;
        end
        chk("space_wait_timeout", 64'(n >= 5000), 64'(0));
      end else begin
        drops++;
      end
      send_frame(len, lk, bad, kp, 15);
    end
    rdy_mode = 0;
    drain(3000);
    chk("rand_drops", 64'(ovf_seen - o0), 64'(drops));
    chk("rand_fq_end", 64'(frames_queued), 64'(0));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef ETH_TX_FIFO_STATS_EN
    chk("stat_tx_frames", 64'(stat_tx_frames), 64'(rx_frames - tx0));
    chk("stat_drop_frames", 64'(stat_drop_frames), 64'(ovf_seen - d0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
